// File: rtl/td4_pkg.sv
// Shared TD4 definitions: controller state encoding, program depth and the
// ROM byte layout that the core decodes.
package td4_pkg;
   localparam logic [1:0] ST_HALT   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_LDDONE = 2'd2;
   localparam logic [1:0] ST_RUN    = 2'd3;

   localparam int PROG_DEPTH = 16;
   localparam logic [3:0] LAST_ADDR = 4'(PROG_DEPTH - 1);

   // One program byte as the core sees it.
   typedef struct packed {
      logic [3:0] op;
      logic [3:0] imm;
   } td4_insn_t;
endpackage

// File: rtl/td4_rate_div.sv
// Free-run rate divider: counts enabled cycles and flags the cycle in which
// a RUN pulse is due (every DIV enabled cycles), then wraps.
module td4_rate_div #(
   parameter int DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic due
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   assign due = en && (cnt == LAST);

   // Count enabled cycles; synchronous clear keeps it at 0 outside RUN.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)      cnt <= '0;
      else if (clr)    cnt <= '0;
      else if (en)     cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
   end
endmodule

// File: rtl/td4_run_ctrl.sv
// TD4 run/load controller: streams the program into the 16x8 ROM, holds the
// core in reset while loading, then meters execution through cpu_en.
module td4_run_ctrl
   import td4_pkg::*;
#(
   parameter int DIV   = 4,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_req,
   input  logic             run_req,
   input  logic             step_req,
   input  logic             halt_req,
   input  logic             prog_valid,
   input  logic [7:0]       prog_data,
   output logic             prog_ready,
   output logic             mem_we,
   output logic [3:0]       mem_addr,
   output logic [7:0]       mem_wdata,
   input  logic [3:0]       ip,
   input  logic             bp_en,
   input  logic [3:0]       bp_addr,
   output logic             cpu_en,
   output logic             cpu_rst_n,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] retired
);
   localparam logic [CNT_W-1:0] RET_MAX = {CNT_W{1'b1}};

   logic [1:0] nxt;
   logic [3:0] addr_cnt;
   logic       first_r;   // next RUN pulse is the first since entry
   logic       hs, run_go, step_go, div_en, due, bp_hit, pulse;

   assign hs      = (state == ST_LOAD) && prog_valid && prog_ready && !load_req;
   assign run_go  = (state == ST_HALT) && run_req && !load_req && !halt_req;
   assign step_go = (state == ST_HALT) && step_req && !load_req && !halt_req && !run_req;
   // The divider starts counting in the run_req cycle so DIV=1 pulses at t+1.
   assign div_en  = run_go || (state == ST_RUN);
   assign bp_hit  = bp_en && (ip == bp_addr) && !first_r;
   assign pulse   = step_go ||
                    (due && (run_go ||
                             ((state == ST_RUN) && !load_req && !halt_req && !bp_hit)));

   td4_rate_div #(.DIV(DIV)) u_div (
      .clock (clock),
      .reset (reset),
      .clr   (!div_en),
      .en    (div_en),
      .due   (due)
   );

   // Next-state selection with load > halt > run > step priority.
   always_comb begin
      nxt = state;
      case (state)
         ST_HALT:   if (load_req) nxt = ST_LOAD;
                    else if (!halt_req && run_req) nxt = ST_RUN;
         ST_LOAD:   if (load_req) nxt = ST_LOAD;
                    else if (hs && (addr_cnt == LAST_ADDR)) nxt = ST_LDDONE;
         ST_LDDONE: nxt = ST_HALT;
         ST_RUN:    if (load_req) nxt = ST_LOAD;
                    else if (halt_req || (due && bp_hit)) nxt = ST_HALT;
         default:   nxt = ST_HALT;
      endcase
   end

   // State, handshake/reset outputs and the registered ROM write port.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_HALT;
         prog_ready <= 1'b0;
         cpu_rst_n  <= 1'b0;
         cpu_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state      <= nxt;
         prog_ready <= (nxt == ST_LOAD);
         cpu_rst_n  <= (nxt != ST_LOAD) && (nxt != ST_LDDONE);
         cpu_en     <= pulse;
         mem_we     <= hs;
         mem_addr   <= hs ? addr_cnt  : '0;
         mem_wdata  <= hs ? prog_data : '0;
      end
   end

   // Load address: every load_req (re)starts at 0, each accepted byte advances.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)        addr_cnt <= '0;
      else if (load_req) addr_cnt <= '0;
      else if (hs)       addr_cnt <= addr_cnt + 4'd1;
   end

   // First-pulse flag so a run started on a breakpoint address makes progress.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)       first_r <= 1'b0;
      else if (run_go)  first_r <= !pulse;
      else if (pulse)   first_r <= 1'b0;
   end

   // Retired-instruction counter: cleared by a completed load, saturating.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                             retired <= '0;
      else if (nxt == ST_LDDONE)              retired <= '0;
      else if (pulse && (retired != RET_MAX)) retired <= retired + CNT_W'(1);
   end
endmodule
